// File: rtl/pci_cfg_arbiter.sv
// Shares the config register-file port between the PCI bus FSM (port A) and
// local device logic (port B): A has priority, B is forced through after A_STREAK wins.
module pci_cfg_arbiter #(
   parameter int A_STREAK = 4,
   parameter int TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        a_iswrite,
   input  logic [5:0]  a_offset,
   input  logic [31:0] a_wdata,
   input  logic [3:0]  a_be,
   output logic        a_done,
   output logic [31:0] a_rdata,
   output logic        a_err,
   input  logic        b_req,
   input  logic        b_iswrite,
   input  logic [5:0]  b_offset,
   input  logic [31:0] b_wdata,
   input  logic [3:0]  b_be,
   output logic        b_done,
   output logic [31:0] b_rdata,
   output logic        b_err,
   output logic        cfg_enable,
   output logic        cfg_iswrite,
   output logic [5:0]  cfg_offset,
   output logic [31:0] cfg_write_val,
   output logic [3:0]  cfg_be,
   input  logic [31:0] cfg_read_val,
   input  logic        cfg_done,
   input  logic        cfg_w_err,
   output logic        busy,
   output logic [1:0]  state_dbg
);
   // Handshake: a requester holds req and its fields until its one-cycle done
   // strobe; cfg_enable is held with stable fields until cfg_done or timeout.
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

   state_t      state, state_next;
   logic [3:0]  streak;
   logic [7:0]  watchdog;
   logic        owner_b;
   logic        grant_a, grant_b, timed_out;
   logic [31:0] resp_rdata;
   logic        resp_err;

   always_comb begin
      grant_b    = b_req && (!a_req || streak == 4'(A_STREAK));
      grant_a    = a_req && !grant_b;
      timed_out  = (watchdog == 8'(TIMEOUT - 1)) && !cfg_done;
      state_next = state;
      case (state)
         IDLE:    if (grant_a || grant_b) state_next = ISSUE;
         ISSUE:   if (cfg_done || timed_out) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A missing cfg_done completes as an all-ones read with the error flag set.
   always_comb begin
      resp_rdata = 32'hFFFF_FFFF;
      resp_err   = 1'b1;
      if (cfg_done) begin
         resp_rdata = cfg_iswrite ? 32'h0 : cfg_read_val;
         resp_err   = cfg_iswrite & cfg_w_err;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         streak        <= 4'd0;
         watchdog      <= 8'd0;
         owner_b       <= 1'b0;
         cfg_iswrite   <= 1'b0;
         cfg_offset    <= 6'd0;
         cfg_write_val <= 32'h0;
         cfg_be        <= 4'd0;
         a_rdata       <= 32'h0;
         a_err         <= 1'b0;
         b_rdata       <= 32'h0;
         b_err         <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (grant_a || grant_b) begin
                  owner_b       <= grant_b;
                  cfg_iswrite   <= grant_b ? b_iswrite : a_iswrite;
                  cfg_offset    <= grant_b ? b_offset  : a_offset;
                  cfg_write_val <= grant_b ? b_wdata   : a_wdata;
                  cfg_be        <= grant_b ? b_be      : a_be;
                  streak        <= (grant_b || !b_req) ? 4'd0 : streak + 4'd1;
                  watchdog      <= 8'd0;
               end
            end
            ISSUE: begin
               watchdog <= watchdog + 8'd1;
               if (cfg_done || timed_out) begin
                  if (owner_b) begin
                     b_rdata <= resp_rdata;
                     b_err   <= resp_err;
                  end else begin
                     a_rdata <= resp_rdata;
                     a_err   <= resp_err;
                  end
               end
            end
            RESP:    watchdog <= 8'd0;
            default: watchdog <= 8'd0;
         endcase
      end
   end

   assign cfg_enable = (state == ISSUE);
   assign busy       = (state != IDLE);
   assign a_done     = (state == RESP) && !owner_b;
   assign b_done     = (state == RESP) && owner_b;
   assign state_dbg  = state;

endmodule

// File: tb/tb_pci_cfg_arbiter.sv
// Bench for pci_cfg_arbiter: transaction-level reference model compared every
// cycle, directed scenarios pinned with literal values, then random traffic.
module tb_pci_cfg_arbiter;
   localparam int A_STREAK = 4;
   localparam int TIMEOUT  = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req, a_iswrite, b_req, b_iswrite;
   logic [5:0]  a_offset, b_offset;
   logic [31:0] a_wdata, b_wdata;
   logic [3:0]  a_be, b_be;
   logic        a_done, a_err, b_done, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic        cfg_enable, cfg_iswrite, cfg_done, cfg_w_err, busy;
   logic [5:0]  cfg_offset;
   logic [31:0] cfg_write_val, cfg_read_val;
   logic [3:0]  cfg_be;
   logic [1:0]  state_dbg;

   pci_cfg_arbiter #(.A_STREAK(A_STREAK), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_iswrite(a_iswrite), .a_offset(a_offset), .a_wdata(a_wdata), .a_be(a_be),
      .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_iswrite(b_iswrite), .b_offset(b_offset), .b_wdata(b_wdata), .b_be(b_be),
      .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
      .cfg_enable(cfg_enable), .cfg_iswrite(cfg_iswrite), .cfg_offset(cfg_offset),
      .cfg_write_val(cfg_write_val), .cfg_be(cfg_be), .cfg_read_val(cfg_read_val),
      .cfg_done(cfg_done), .cfg_w_err(cfg_w_err), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          t_live, t_b;
   int          t_age, t_len, m_a_run;
   logic        m_wr;
   logic [5:0]  m_off;
   logic [31:0] m_wdata, m_a_rdata, m_b_rdata;
   logic [3:0]  m_be;
   logic        m_a_err, m_b_err;
   logic [33:0] exp_q[$];
   int          len_q[$];
   bit          grant_q[$];

   task automatic model_reset();
      t_live = 0; t_b = 0; t_age = 0; t_len = 0; m_a_run = 0;
      m_wr = 0; m_off = '0; m_wdata = '0; m_be = '0;
      m_a_rdata = '0; m_a_err = 0; m_b_rdata = '0; m_b_err = 0;
   endtask

   task automatic model_step();
      logic [31:0] r;
      logic        e;
      if (t_live && t_len == 0) begin
         t_age++;
         if (cfg_done || t_age == TIMEOUT) begin
            t_len = t_age;
            if (!cfg_done) begin r = 32'hFFFF_FFFF; e = 1'b1; end
            else if (m_wr) begin r = 32'h0; e = cfg_w_err; end
            else           begin r = cfg_read_val; e = 1'b0; end
            if (t_b) begin m_b_rdata = r; m_b_err = e; end
            else     begin m_a_rdata = r; m_a_err = e; end
            exp_q.push_back({t_b, e, r});
            len_q.push_back(t_len);
         end
      end else if (t_live) begin
         t_live = 0;
      end else if (a_req || b_req) begin
         t_b = b_req && (m_a_run >= A_STREAK || !a_req);
         m_a_run = (t_b || !b_req) ? 0 : m_a_run + 1;
         m_wr    = t_b ? b_iswrite : a_iswrite;
         m_off   = t_b ? b_offset  : a_offset;
         m_wdata = t_b ? b_wdata   : a_wdata;
         m_be    = t_b ? b_be      : a_be;
         t_live = 1; t_age = 0; t_len = 0;
         grant_q.push_back(t_b);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) model_reset();
      chk("busy",       busy,          t_live);
      chk("cfg_enable", cfg_enable,    t_live && t_len == 0);
      chk("a_done",     a_done,        t_live && t_len != 0 && !t_b);
      chk("b_done",     b_done,        t_live && t_len != 0 && t_b);
      chk("a_rdata",    a_rdata,       m_a_rdata);
      chk("a_err",      a_err,         m_a_err);
      chk("b_rdata",    b_rdata,       m_b_rdata);
      chk("b_err",      b_err,         m_b_err);
      chk("cfg_iswrite", cfg_iswrite,  m_wr);
      chk("cfg_offset", cfg_offset,    m_off);
      chk("cfg_wval",   cfg_write_val, m_wdata);
      chk("cfg_be",     cfg_be,        m_be);
      chk("both_done",  a_done & b_done, 1'b0);
      if (rst) model_step();
   end

   // ---------------- drivers ----------------
   int          rf_fixed = 1;
   bit          rf_val_fixed = 1;
   logic [31:0] rf_val = '0;
   logic        rf_werr = 0;
   bit          spur_on = 0;
   bit          rnd_on = 0;
   bit          rnd_stop = 0;
   int          en_cnt = 0;
   int          rf_d = 0;
   int          n_done = 0;
   bit          dut_q[$];

   task automatic rf_drive();
      int k;
      if (cfg_enable) begin
         if (en_cnt == 0) begin
            if (rf_fixed >= 0) rf_d = rf_fixed;
            else begin
               k = int'($urandom_range(0, 7));
               rf_d = (k == 0) ? 0 : (k == 1) ? TIMEOUT : int'($urandom_range(1, 5));
            end
         end
         en_cnt++;
         cfg_done = (rf_d != 0) && (en_cnt == rf_d);
      end else begin
         en_cnt = 0;
         cfg_done = spur_on && ($urandom_range(0, 7) == 0);
      end
      if (rf_val_fixed) begin cfg_read_val = rf_val; cfg_w_err = rf_werr; end
      else begin cfg_read_val = $urandom; cfg_w_err = 1'($urandom_range(0, 1)); end
   endtask

   task automatic rnd_drive();
      if (a_req) begin
         if (a_done) begin
            n_done++;
            if (!rnd_stop && $urandom_range(0, 3) == 0) begin
               a_iswrite = 1'($urandom_range(0, 1)); a_offset = 6'($urandom);
               a_wdata = $urandom; a_be = 4'($urandom);
            end else a_req = 0;
         end
      end else if (!rnd_stop && $urandom_range(0, 2) == 0) begin
         a_req = 1; a_iswrite = 1'($urandom_range(0, 1)); a_offset = 6'($urandom);
         a_wdata = $urandom; a_be = 4'($urandom);
      end
      if (b_req) begin
         if (b_done) begin
            n_done++;
            if (!rnd_stop && $urandom_range(0, 3) == 0) begin
               b_iswrite = 1'($urandom_range(0, 1)); b_offset = 6'($urandom);
               b_wdata = $urandom; b_be = 4'($urandom);
            end else b_req = 0;
         end
      end else if (!rnd_stop && $urandom_range(0, 2) == 0) begin
         b_req = 1; b_iswrite = 1'($urandom_range(0, 1)); b_offset = 6'($urandom);
         b_wdata = $urandom; b_be = 4'($urandom);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rf_drive();
      if (rnd_on) rnd_drive();
   endtask

   task automatic run_one(input bit pb, input bit wr, input logic [5:0] off, input logic [31:0] wd,
                          input logic [3:0] be, input int d, input logic [31:0] rv, input logic we,
                          output int other_done);
      bit got = 0;
      exp_q.delete(); len_q.delete();
      rf_fixed = d; rf_val_fixed = 1; rf_val = rv; rf_werr = we;
      if (pb) begin b_iswrite = wr; b_offset = off; b_wdata = wd; b_be = be; b_req = 1; end
      else    begin a_iswrite = wr; a_offset = off; a_wdata = wd; a_be = be; a_req = 1; end
      other_done = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         step();
         if (pb ? a_done : b_done) other_done++;
         if (pb ? b_done : a_done) begin
            got = 1;
            if (pb) b_req = 0; else a_req = 0;
         end
      end
      chk("wait_done", got, 1'b1);
      repeat (2) step();
   endtask

   task automatic pop_chk(input string name, input logic [33:0] exp_resp, input int exp_len);
      chk({name, "_count"}, exp_q.size(), 1);
      if (exp_q.size() > 0) chk({name, "_resp"}, exp_q.pop_front(), exp_resp);
      if (len_q.size() > 0) chk({name, "_enable_cycles"}, len_q.pop_front(), exp_len);
   endtask

   task automatic run_both(input int n, output int both);
      dut_q.delete(); grant_q.delete();
      rf_fixed = 1; a_req = 1; b_req = 1; both = 0;
      for (int i = 0; i < 400 && dut_q.size() < n; i++) begin
         step();
         if (a_done && b_done) both++;
         if (a_done) dut_q.push_back(1'b0);
         else if (b_done) dut_q.push_back(1'b1);
      end
      a_req = 0; b_req = 0;
      repeat (2) step();
   endtask

   function automatic logic [31:0] pack_q(input bit q[$]);
      logic [31:0] v = '0;
      foreach (q[i]) v = {v[30:0], q[i]};
      return v;
   endfunction

   // ---------------- directed + random sequence ----------------
   initial begin
      int od, both;
      bit got;
      a_req = 0; a_iswrite = 0; a_offset = '0; a_wdata = '0; a_be = '0;
      b_req = 0; b_iswrite = 0; b_offset = '0; b_wdata = '0; b_be = '0;
      cfg_done = 0; cfg_read_val = '0; cfg_w_err = 0;
      #2 rst = 0;
      repeat (2) step();
      chk("rst_state", state_dbg, 2'd0);
      rst = 1;
      repeat (3) step();
      chk("idle_busy", busy, 1'b0);
      chk("idle_enable", cfg_enable, 1'b0);
      chk("idle_a_rdata", a_rdata, 32'h0);

      // A read, register file answers in the first enable cycle
      run_one(0, 0, 6'h04, 32'h0, 4'h0, 1, 32'h1234_5678, 1'b0, od);
      pop_chk("a_read", {1'b0, 1'b0, 32'h1234_5678}, 1);
      chk("a_read_rdata", a_rdata, 32'h1234_5678);
      chk("a_read_err", a_err, 1'b0);

      // B write rejected by the register file after 3 cycles
      run_one(1, 1, 6'h01, 32'h0000_0146, 4'b1100, 3, 32'hDEAD_BEEF, 1'b1, od);
      pop_chk("b_write", {1'b1, 1'b1, 32'h0}, 3);
      chk("b_write_other_done", od, 0);
      chk("b_write_err", b_err, 1'b1);
      chk("a_rdata_hold", a_rdata, 32'h1234_5678);

      // both requesting continuously: B forced through after 4 A grants
      run_both(10, both);
      chk("order_dut", pack_q(dut_q), 32'b0000100001);
      chk("order_model", pack_q(grant_q), 32'b0000100001);
      chk("order_both_done", both, 0);

      // register file never answers: watchdog completion, then B served normally
      run_one(0, 0, 6'h10, 32'h0, 4'h0, 0, 32'h5555_5555, 1'b0, od);
      pop_chk("a_timeout", {1'b0, 1'b1, 32'hFFFF_FFFF}, TIMEOUT);
      chk("a_timeout_rdata", a_rdata, 32'hFFFF_FFFF);
      run_one(1, 0, 6'h02, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 1'b0, od);
      pop_chk("b_after_timeout", {1'b1, 1'b0, 32'hCAFE_F00D}, 2);

      // reset in the middle of a B write
      rf_fixed = 0;
      b_iswrite = 1; b_offset = 6'h3F; b_wdata = 32'hA5A5_A5A5; b_be = 4'h0; b_req = 1;
      repeat (3) step();
      rst = 0;
      #1;
      chk("rst_cfg_enable", cfg_enable, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_b_done", b_done, 1'b0);
      chk("rst_b_rdata", b_rdata, 32'h0);
      chk("rst_cfg_offset", cfg_offset, 6'h0);
      b_req = 0; a_req = 1;
      repeat (2) step();
      rst = 1;
      run_both(5, both);
      chk("post_rst_order", pack_q(dut_q), 32'b00001);

      // reset while streak is at its limit: the count must restart
      run_both(3, both);
      chk("streak_build", pack_q(dut_q), 32'b000);
      rf_fixed = 0; a_req = 1; b_req = 1; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         got = cfg_enable;
      end
      chk("streak_issue_seen", got, 1'b1);
      repeat (2) step();
      rst = 0;
      repeat (2) step();
      rst = 1;
      run_both(5, both);
      chk("streak_restart_order", pack_q(dut_q), 32'b00001);

      // random traffic with random register-file latency and stray cfg_done
      rf_fixed = -1; rf_val_fixed = 0; spur_on = 1; rnd_on = 1;
      repeat (3000) step();
      rnd_stop = 1;
      for (int i = 0; i < 200 && (a_req || b_req); i++) step();
      chk("drain", a_req | b_req, 1'b0);
      chk("rand_activity", n_done > 50, 1'b1);
      rnd_on = 0; spur_on = 0;
      repeat (4) step();
      chk("final_busy", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
